// File: rtl/if_fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
package if_fetch_pkg;

  localparam int ADDR_W           = 32;
  localparam int INSTR_W          = 32;
  localparam int INSTR_SIZE_BYTES = 4;
  localparam logic [INSTR_W-1:0] INSTR_BUBBLE = '0;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  function automatic logic [ADDR_W-1:0] align_pc(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous prefetch FIFO with combinational head and synchronous flush.
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     areset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  input  logic                     flush,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty,
  output logic [WIDTH-1:0]         head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  // Storage needs no reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/if_fetch.sv
// Instruction-fetch stage: in-order imem requests, prefetch FIFO, and
// wrong-path response dropping after redirect or clr.
module if_fetch
  import if_fetch_pkg::*;
#(
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               areset,
  input  logic               clr,
  input  logic               stall,
  input  logic               i_redirect_en,
  input  logic [ADDR_W-1:0]  i_redirect_pc,
  output logic               o_imem_req,
  output logic [ADDR_W-1:0]  o_imem_addr,
  input  logic               i_imem_gnt,
  input  logic               i_imem_rvalid,
  input  logic [INSTR_W-1:0] i_imem_rdata,
  output logic [ADDR_W-1:0]  o_pc,
  output logic [INSTR_W-1:0] o_instr,
  output logic               o_valid
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_W-1:0] fetch_pc;
  logic [ADDR_W-1:0] resp_pc;
  logic [CNT_W-1:0]  outstanding;
  logic [CNT_W-1:0]  drop_cnt;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W:0]    in_use;
  logic              fifo_full;
  logic              fifo_empty;
  logic              fifo_push;
  logic              fifo_pop;
  logic              fire;
  logic              flush;
  logic [ADDR_W-1:0] flush_pc;
  fetch_entry_t      push_entry;
  fetch_entry_t      head;

  assign flush    = clr || i_redirect_en;
  assign flush_pc = clr ? RESET_PC : align_pc(i_redirect_pc);
  assign in_use   = {1'b0, outstanding} + {1'b0, fifo_count};

  // Handshake: a request transfers on any cycle with o_imem_req && i_imem_gnt;
  // the address is held while req waits, and req drops only on clr/redirect.
  // Responses return in order, one per i_imem_rvalid, with no back-pressure,
  // which is why requests are credited against free FIFO entries.
  assign o_imem_req  = !areset && !flush && !fifo_full &&
                       (in_use < (CNT_W+1)'(FIFO_DEPTH));
  assign o_imem_addr = fetch_pc;
  assign fire        = o_imem_req && i_imem_gnt;

  assign fifo_push        = i_imem_rvalid && !flush && (drop_cnt == '0);
  assign push_entry.pc    = resp_pc;
  assign push_entry.instr = i_imem_rdata;

  assign o_valid  = !fifo_empty && !flush;
  assign fifo_pop = o_valid && !stall;
  assign o_pc     = o_valid ? head.pc    : '0;
  assign o_instr  = o_valid ? head.instr : INSTR_BUBBLE;

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      fetch_pc    <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      outstanding <= outstanding + CNT_W'(fire) - CNT_W'(i_imem_rvalid);
      if (flush) begin
        fetch_pc <= flush_pc;
        resp_pc  <= flush_pc;
        // Everything still in flight after this cycle belongs to the old path.
        drop_cnt <= outstanding - CNT_W'(i_imem_rvalid);
      end else begin
        if (fire) fetch_pc <= fetch_pc + ADDR_W'(INSTR_SIZE_BYTES);
        if (i_imem_rvalid) begin
          if (drop_cnt != '0) drop_cnt <= drop_cnt - 1'b1;
          else                resp_pc  <= resp_pc + ADDR_W'(INSTR_SIZE_BYTES);
        end
      end
    end
  end

  fetch_fifo #(
    .WIDTH($bits(fetch_entry_t)),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .areset(areset),
    .push  (fifo_push),
    .wdata (push_entry),
    .pop   (fifo_pop),
    .flush (flush),
    .count (fifo_count),
    .full  (fifo_full),
    .empty (fifo_empty),
    .head  (head)
  );

endmodule

// File: tb/tb_if_fetch.sv
// Scoreboard bench for if_fetch: memory model with grant budget, decoupled pop monitor.
module tb_if_fetch;

  localparam int FIFO_DEPTH = 2;

  logic        clk = 1'b0;
  logic        areset;
  logic        clr;
  logic        stall;
  logic        i_redirect_en;
  logic [31:0] i_redirect_pc;
  logic        o_imem_req;
  logic [31:0] o_imem_addr;
  logic        i_imem_gnt;
  logic        i_imem_rvalid;
  logic [31:0] i_imem_rdata;
  logic [31:0] o_pc;
  logic [31:0] o_instr;
  logic        o_valid;

  int checks = 0;
  int errors = 0;
  int budget = 0;
  logic rsp_en = 1'b1;
  logic mon_en = 1'b1;

  logic [63:0] exp_q[$];
  logic [31:0] pend_q[$];

  always #5 clk = ~clk;

  assign i_imem_gnt = (budget != 0);

  if_fetch #(.RESET_PC(32'h0), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .clk          (clk),
    .areset       (areset),
    .clr          (clr),
    .stall        (stall),
    .i_redirect_en(i_redirect_en),
    .i_redirect_pc(i_redirect_pc),
    .o_imem_req   (o_imem_req),
    .o_imem_addr  (o_imem_addr),
    .i_imem_gnt   (i_imem_gnt),
    .i_imem_rvalid(i_imem_rvalid),
    .i_imem_rdata (i_imem_rdata),
    .o_pc         (o_pc),
    .o_instr      (o_instr),
    .o_valid      (o_valid)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'hC0DE_0000 ^ a;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic exp_stream(input logic [31:0] base, input int n);
    for (int k = 0; k < n; k++) exp_q.push_back({base + 32'(4*k), mem_word(base + 32'(4*k))});
  endtask

  task automatic wait_drain(input string name);
    int done;
    done = 0;
    for (int i = 0; i < 300 && done == 0; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && budget == 0 && pend_q.size() == 0) done = 1;
    end
    checks++;
    if (done == 0) begin
      errors++;
      $display("FAIL %s_drain actual=%0d_left required=0_left", name, exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic redir(input logic [31:0] pc, input logic rsp_next);
    @(posedge clk); #2;
    i_redirect_en = 1'b1;
    i_redirect_pc = pc;
    rsp_en = rsp_next;
    @(negedge clk);
    chk("redir_valid", {31'b0, o_valid}, 32'd0);
    chk("redir_instr", o_instr, 32'd0);
    chk("redir_req", {31'b0, o_imem_req}, 32'd0);
    @(posedge clk); #2;
    i_redirect_en = 1'b0;
  endtask

  // Memory model: grants from the budget, answers one cycle after grant when enabled.
  initial begin
    logic        fire_s;
    logic [31:0] a_s;
    i_imem_rvalid = 1'b0;
    i_imem_rdata  = '0;
    forever begin
      @(negedge clk);
      fire_s = o_imem_req && i_imem_gnt && !areset;
      a_s    = o_imem_addr;
      @(posedge clk); #1;
      if (areset) begin
        pend_q.delete();
        i_imem_rvalid = 1'b0;
        i_imem_rdata  = '0;
      end else begin
        if (fire_s) begin
          pend_q.push_back(a_s);
          budget--;
        end
        if (rsp_en && pend_q.size() > 0) begin
          i_imem_rvalid = 1'b1;
          i_imem_rdata  = mem_word(pend_q.pop_front());
        end else begin
          i_imem_rvalid = 1'b0;
          i_imem_rdata  = '0;
        end
      end
    end
  end

  // Monitor: compare every instruction decode accepts against the scoreboard.
  always @(negedge clk) begin
    logic [63:0] exp;
    if (!areset) begin
      checks++;
      if (32'(dut.outstanding) + 32'(dut.fifo_count) > FIFO_DEPTH) begin
        errors++;
        $display("FAIL credit actual=%0d required_max=%0d",
                 32'(dut.outstanding) + 32'(dut.fifo_count), FIFO_DEPTH);
      end
    end
    if (mon_en && !areset && o_valid && !stall && !clr && !i_redirect_en) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected actual=%h_%h required=none", o_pc, o_instr);
      end else begin
        exp = exp_q.pop_front();
        if ({o_pc, o_instr} !== exp) begin
          errors++;
          $display("FAIL pop actual=%h_%h required=%h_%h", o_pc, o_instr, exp[63:32], exp[31:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    areset = 1'b1; clr = 1'b0; stall = 1'b0;
    i_redirect_en = 1'b0; i_redirect_pc = '0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_req", {31'b0, o_imem_req}, 32'd0);
    chk("rst_pc", o_pc, 32'd0);
    chk("rst_instr", o_instr, 32'd0);
    chk("rst_valid", {31'b0, o_valid}, 32'd0);
    @(posedge clk); #2;
    areset = 1'b0;
    @(negedge clk);
    chk("p1_req", {31'b0, o_imem_req}, 32'd1);
    chk("p1_addr", o_imem_addr, 32'h0);

    // Streaming from RESET_PC
    @(posedge clk); #2;
    exp_stream(32'h0, 8);
    budget = 8;
    wait_drain("p1");
    @(negedge clk);
    chk("p1_hold_addr", o_imem_addr, 32'h20);
    chk("p1_hold_req", {31'b0, o_imem_req}, 32'd1);

    // Stall with memory streaming: credits run out, head held
    @(posedge clk); #2;
    stall = 1'b1;
    exp_stream(32'h20, 8);
    budget = 8;
    repeat (5) @(negedge clk);
    chk("p2_req", {31'b0, o_imem_req}, 32'd0);
    chk("p2_pc", o_pc, 32'h20);
    chk("p2_valid", {31'b0, o_valid}, 32'd1);
    @(posedge clk); #2;
    stall = 1'b0;
    wait_drain("p2");

    // Two outstanding (0x10, 0x14) then redirect to 0x103
    redir(32'h10, 1'b1);
    rsp_en = 1'b0;
    budget = 2;
    repeat (3) @(negedge clk);
    redir(32'h103, 1'b1);
    @(negedge clk);
    chk("p3_addr", o_imem_addr, 32'h100);
    @(posedge clk); #2;
    exp_stream(32'h100, 4);
    budget = 4;
    wait_drain("p3");

    // Redirect in the same cycle as a response, one more in flight
    @(posedge clk); #2;
    rsp_en = 1'b0;
    budget = 2;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    rsp_en = 1'b1;
    redir(32'h300, 1'b1);
    @(negedge clk);
    chk("p4_addr", o_imem_addr, 32'h300);
    @(posedge clk); #2;
    exp_stream(32'h300, 4);
    budget = 4;
    wait_drain("p4");

    // clr with simultaneous redirect while FIFO holds stalled words
    @(posedge clk); #2;
    stall = 1'b1;
    budget = 2;
    repeat (4) @(negedge clk);
    @(posedge clk); #2;
    clr = 1'b1;
    i_redirect_en = 1'b1;
    i_redirect_pc = 32'h200;
    @(negedge clk);
    chk("p5_instr", o_instr, 32'd0);
    chk("p5_valid", {31'b0, o_valid}, 32'd0);
    chk("p5_req", {31'b0, o_imem_req}, 32'd0);
    @(posedge clk); #2;
    clr = 1'b0;
    i_redirect_en = 1'b0;
    stall = 1'b0;
    @(negedge clk);
    chk("p5_addr", o_imem_addr, 32'h0);
    chk("p5_req_after", {31'b0, o_imem_req}, 32'd1);
    @(posedge clk); #2;
    exp_stream(32'h0, 4);
    budget = 4;
    wait_drain("p5");

    // areset mid-stream
    @(posedge clk); #2;
    mon_en = 1'b0;
    budget = 6;
    repeat (3) @(negedge clk);
    @(posedge clk); #2;
    areset = 1'b1;
    budget = 0;
    #1;
    chk("p6_req", {31'b0, o_imem_req}, 32'd0);
    chk("p6_valid", {31'b0, o_valid}, 32'd0);
    chk("p6_instr", o_instr, 32'd0);
    repeat (2) @(posedge clk);
    #2;
    areset = 1'b0;
    rsp_en = 1'b1;
    exp_q.delete();
    mon_en = 1'b1;
    @(negedge clk);
    chk("p6_addr", o_imem_addr, 32'h0);
    chk("p6_req_after", {31'b0, o_imem_req}, 32'd1);
    @(posedge clk); #2;
    exp_stream(32'h0, 4);
    budget = 4;
    wait_drain("p6");

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
